// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_unit : five-stage pipeline control path with D decode, E/M/W     |
// | control registers and a multi-cycle multiply-busy tracker.                 |
// | Optional feature macro: JUMP_EN (decode of the j instruction).             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_ctrl_unit #(
  parameter int ALUC_W     = 3,
  parameter int MEM_STAGES = 1,
  parameter int MUL_LAT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        Funct,
  input  logic              EqualD,
  input  logic              FlushE,
  output logic              BranchD,
  output logic              BneD,
  output logic              JumpD,
  output logic              PCSrcD,
  output logic              SgnZeroD,
  output logic              StallMD,
  output logic              RegDstE,
  output logic              ALUSrcE,
  output logic              MemtoRegE,
  output logic              RegWriteE,
  output logic              MultStartE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              MultBusy,
  output logic              MemWriteM,
  output logic              MemtoRegM,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegW
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  logic       reg_write_d;
  logic       mem_to_reg_d;
  logic       mem_write_d;
  logic       alu_src_d;
  logic       reg_dst_d;
  logic       branch_d;
  logic       bne_d;
  logic       sgn_zero_d;
  logic       mult_start_d;
  logic [2:0] alu_op_d;
`ifdef JUMP_EN
  logic       jump_d;
`endif

  logic       mem_write_e;
  mul_state_t mul_state;
  logic [CNT_W-1:0] mul_cnt;
  logic [1:0] mw_pipe [MEM_STAGES];

  always_comb begin
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    reg_dst_d    = 1'b0;
    branch_d     = 1'b0;
    bne_d        = 1'b0;
    sgn_zero_d   = 1'b0;
    mult_start_d = 1'b0;
    alu_op_d     = ALU_AND;
`ifdef JUMP_EN
    jump_d       = 1'b0;
`endif
    case (op)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_op_d = ALU_ADD; end
          FN_SUB:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_op_d = ALU_SUB; end
          FN_AND:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_op_d = ALU_AND; end
          FN_OR:   begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_op_d = ALU_OR;  end
          FN_SLT:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_op_d = ALU_SLT; end
          // mult keeps the R-type destination select but never writes the register file
          FN_MULT: begin mult_start_d = 1'b1; reg_dst_d = 1'b1; end
          default: ;
        endcase
      end
      OP_LW:   begin reg_write_d = 1'b1; mem_to_reg_d = 1'b1; alu_src_d = 1'b1; alu_op_d = ALU_ADD; end
      OP_SW:   begin mem_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = ALU_ADD; end
      OP_BEQ:  begin branch_d = 1'b1; alu_op_d = ALU_SUB; end
      OP_BNE:  begin branch_d = 1'b1; bne_d = 1'b1; alu_op_d = ALU_SUB; end
      OP_ADDI: begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = ALU_ADD; end
      OP_ANDI: begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = ALU_AND; sgn_zero_d = 1'b1; end
      OP_ORI:  begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = ALU_OR;  sgn_zero_d = 1'b1; end
`ifdef JUMP_EN
      OP_J:    jump_d = 1'b1;
`endif
      default: ;
    endcase
  end

  assign BranchD  = branch_d;
  assign BneD     = bne_d;
  assign SgnZeroD = sgn_zero_d;
  assign PCSrcD   = branch_d & (EqualD ^ bne_d);
  assign StallMD  = mult_start_d & (MultBusy | MultStartE);
`ifdef JUMP_EN
  assign JumpD    = jump_d;
`else
  assign JumpD    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegDstE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemtoRegE   <= 1'b0;
      RegWriteE   <= 1'b0;
      MultStartE  <= 1'b0;
      mem_write_e <= 1'b0;
      ALUControlE <= '0;
    end else if (FlushE || StallMD) begin
      RegDstE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemtoRegE   <= 1'b0;
      RegWriteE   <= 1'b0;
      MultStartE  <= 1'b0;
      mem_write_e <= 1'b0;
      ALUControlE <= '0;
    end else begin
      RegDstE     <= reg_dst_d;
      ALUSrcE     <= alu_src_d;
      MemtoRegE   <= mem_to_reg_d;
      RegWriteE   <= reg_write_d;
      MultStartE  <= mult_start_d;
      mem_write_e <= mem_write_d;
      ALUControlE <= ALUC_W'(alu_op_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      RegWriteM <= 1'b0;
    end else begin
      MemWriteM <= mem_write_e;
      MemtoRegM <= MemtoRegE;
      RegWriteM <= RegWriteE;
    end
  end

  // Each entry holds {RegWrite, MemtoReg}; the last entry is the W stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_STAGES; i++) begin
        mw_pipe[i] <= 2'b00;
      end
    end else begin
      mw_pipe[0] <= {RegWriteM, MemtoRegM};
      for (int i = 1; i < MEM_STAGES; i++) begin
        mw_pipe[i] <= mw_pipe[i-1];
      end
    end
  end

  assign RegWriteW = mw_pipe[MEM_STAGES-1][1];
  assign MemtoRegW = mw_pipe[MEM_STAGES-1][0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_state <= MUL_IDLE;
      mul_cnt   <= '0;
      MultBusy  <= 1'b0;
    end else begin
      case (mul_state)
        MUL_IDLE: begin
          if (MultStartE) begin
            mul_cnt   <= CNT_W'(MUL_LAT - 1);
            mul_state <= MUL_BUSY;
            MultBusy  <= 1'b1;
          end
        end
        MUL_BUSY: begin
          mul_cnt <= mul_cnt - 1'b1;
          if (mul_cnt == CNT_W'(1)) begin
            mul_state <= MUL_IDLE;
            MultBusy  <= 1'b0;
          end
        end
        default: begin
          mul_state <= MUL_IDLE;
          MultBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// tb_pipe_ctrl_unit: randomized scoreboard bench; two instances (MEM_STAGES=1 and 3)
// share stimulus and are checked against an instruction-level reference model.
module tb_pipe_ctrl_unit;
  localparam int ALUC_W  = 3;
  localparam int MUL_LAT = 4;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, JOP = 6'b000010;
  localparam logic [5:0] RT = 6'b000000, MULT = 6'b011000;

  logic clk = 1'b0, reset = 1'b0, EqualD = 1'b0, FlushE = 1'b0;
  logic [5:0] op = 6'd0, Funct = 6'd0;

  logic a_BranchD, a_BneD, a_JumpD, a_PCSrcD, a_SgnZeroD, a_StallMD;
  logic a_RegDstE, a_ALUSrcE, a_MemtoRegE, a_RegWriteE, a_MultStartE, a_MultBusy;
  logic a_MemWriteM, a_MemtoRegM, a_RegWriteM, a_RegWriteW, a_MemtoRegW;
  logic [ALUC_W-1:0] a_ALUControlE;
  logic b_BranchD, b_BneD, b_JumpD, b_PCSrcD, b_SgnZeroD, b_StallMD;
  logic b_RegDstE, b_ALUSrcE, b_MemtoRegE, b_RegWriteE, b_MultStartE, b_MultBusy;
  logic b_MemWriteM, b_MemtoRegM, b_RegWriteM, b_RegWriteW, b_MemtoRegW;
  logic [ALUC_W-1:0] b_ALUControlE;

  pipe_ctrl_unit #(.ALUC_W(ALUC_W), .MEM_STAGES(1), .MUL_LAT(MUL_LAT)) dut_a (
    .clk(clk), .reset(reset), .op(op), .Funct(Funct), .EqualD(EqualD), .FlushE(FlushE),
    .BranchD(a_BranchD), .BneD(a_BneD), .JumpD(a_JumpD), .PCSrcD(a_PCSrcD),
    .SgnZeroD(a_SgnZeroD), .StallMD(a_StallMD), .RegDstE(a_RegDstE), .ALUSrcE(a_ALUSrcE),
    .MemtoRegE(a_MemtoRegE), .RegWriteE(a_RegWriteE), .MultStartE(a_MultStartE),
    .ALUControlE(a_ALUControlE), .MultBusy(a_MultBusy), .MemWriteM(a_MemWriteM),
    .MemtoRegM(a_MemtoRegM), .RegWriteM(a_RegWriteM), .RegWriteW(a_RegWriteW),
    .MemtoRegW(a_MemtoRegW));

  pipe_ctrl_unit #(.ALUC_W(ALUC_W), .MEM_STAGES(3), .MUL_LAT(MUL_LAT)) dut_b (
    .clk(clk), .reset(reset), .op(op), .Funct(Funct), .EqualD(EqualD), .FlushE(FlushE),
    .BranchD(b_BranchD), .BneD(b_BneD), .JumpD(b_JumpD), .PCSrcD(b_PCSrcD),
    .SgnZeroD(b_SgnZeroD), .StallMD(b_StallMD), .RegDstE(b_RegDstE), .ALUSrcE(b_ALUSrcE),
    .MemtoRegE(b_MemtoRegE), .RegWriteE(b_RegWriteE), .MultStartE(b_MultStartE),
    .ALUControlE(b_ALUControlE), .MultBusy(b_MultBusy), .MemWriteM(b_MemWriteM),
    .MemtoRegM(b_MemtoRegM), .RegWriteM(b_RegWriteM), .RegWriteW(b_RegWriteW),
    .MemtoRegW(b_MemtoRegW));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] d_a, d_b, e_a, e_b, m_a, m_b, w_a, w_b, bz_a, bz_b;
  assign d_a  = 16'({a_BranchD, a_BneD, a_JumpD, a_PCSrcD, a_SgnZeroD, a_StallMD});
  assign d_b  = 16'({b_BranchD, b_BneD, b_JumpD, b_PCSrcD, b_SgnZeroD, b_StallMD});
  assign e_a  = 16'({a_RegDstE, a_ALUSrcE, a_MemtoRegE, a_RegWriteE, a_MultStartE, a_ALUControlE});
  assign e_b  = 16'({b_RegDstE, b_ALUSrcE, b_MemtoRegE, b_RegWriteE, b_MultStartE, b_ALUControlE});
  assign m_a  = 16'({a_MemWriteM, a_MemtoRegM, a_RegWriteM});
  assign m_b  = 16'({b_MemWriteM, b_MemtoRegM, b_RegWriteM});
  assign w_a  = 16'({a_RegWriteW, a_MemtoRegW});
  assign w_b  = 16'({b_RegWriteW, b_MemtoRegW});
  assign bz_a = 16'(a_MultBusy);
  assign bz_b = 16'(b_MultBusy);

  int checks = 0, errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] v;
  } ent_t;
  ent_t qd[$], qe[$], qm[$], qw1[$], qw3[$], qb[$];

  // Reference model state: cycle in which the most recent mult occupied E.
  int last_e = -1000;

  typedef struct packed {
    logic rw, mtr, mw, alusrc, rdst, br, bne, jmp, sz, ms;
    logic [2:0] alu;
  } ctl_t;

  function automatic ctl_t decode(input logic [5:0] o, input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (o)
      RT: begin
        case (f)
          6'b100000: c.alu = 3'b010;
          6'b100010: c.alu = 3'b110;
          6'b100100: c.alu = 3'b000;
          6'b100101: c.alu = 3'b001;
          6'b101010: c.alu = 3'b111;
          MULT:      c.ms  = 1'b1;
          default:   return '0;
        endcase
        c.rdst = 1'b1;
        c.rw   = !c.ms;
      end
      LW:   begin c.rw = 1; c.mtr = 1; c.alusrc = 1; c.alu = 3'b010; end
      SW:   begin c.mw = 1; c.alusrc = 1; c.alu = 3'b010; end
      BEQ:  begin c.br = 1; c.alu = 3'b110; end
      BNE:  begin c.br = 1; c.bne = 1; c.alu = 3'b110; end
      ADDI: begin c.rw = 1; c.alusrc = 1; c.alu = 3'b010; end
      ANDI: begin c.rw = 1; c.alusrc = 1; c.alu = 3'b000; c.sz = 1; end
      ORI:  begin c.rw = 1; c.alusrc = 1; c.alu = 3'b001; c.sz = 1; end
`ifdef JUMP_EN
      JOP:  c.jmp = 1;
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic cmp(input string nm, input ent_t e, input logic [15:0] got);
    checks++;
    if (got !== e.v || e.cyc != cyc) begin
      errors++;
      $display("FAIL %s cyc=%0d due=%0d got=%h expected=%h", nm, cyc, e.cyc, got, e.v);
    end
  endtask

  // Issue one instruction in D for one cycle and record every expected response.
  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic eq,
                       input logic fl, output logic stalled);
    ctl_t c, e;
    logic busy_now, me_now, pc;
    @(posedge clk);
    #1;
    op = o; Funct = f; EqualD = eq; FlushE = fl;
    me_now   = (last_e == cyc);
    busy_now = (cyc >= last_e + 1) && (cyc <= last_e + MUL_LAT - 1);
    qb.push_back(ent_t'{cyc, 16'(busy_now)});
    c       = decode(o, f);
    stalled = c.ms && (busy_now || me_now);
    pc      = c.br && (eq ^ c.bne);
    qd.push_back(ent_t'{cyc, 16'({c.br, c.bne, c.jmp, pc, c.sz, stalled})});
    e = (fl || stalled) ? '0 : c;
    if (e.ms) last_e = cyc + 1;
    qe.push_back(ent_t'{cyc + 1, 16'({e.rdst, e.alusrc, e.mtr, e.rw, e.ms, ALUC_W'(e.alu)})});
    qm.push_back(ent_t'{cyc + 2, 16'({e.mw, e.mtr, e.rw})});
    qw1.push_back(ent_t'{cyc + 3, 16'({e.rw, e.mtr})});
    qw3.push_back(ent_t'{cyc + 5, 16'({e.rw, e.mtr})});
  endtask

  always @(negedge clk) begin
    ent_t e;
    while (qd.size() > 0 && qd[0].cyc <= cyc) begin
      e = qd.pop_front(); cmp("d_stage_a", e, d_a); cmp("d_stage_b", e, d_b);
    end
    while (qe.size() > 0 && qe[0].cyc <= cyc) begin
      e = qe.pop_front(); cmp("e_stage_a", e, e_a); cmp("e_stage_b", e, e_b);
    end
    while (qm.size() > 0 && qm[0].cyc <= cyc) begin
      e = qm.pop_front(); cmp("m_stage_a", e, m_a); cmp("m_stage_b", e, m_b);
    end
    while (qw1.size() > 0 && qw1[0].cyc <= cyc) begin
      e = qw1.pop_front(); cmp("w_stage_ms1", e, w_a);
    end
    while (qw3.size() > 0 && qw3[0].cyc <= cyc) begin
      e = qw3.pop_front(); cmp("w_stage_ms3", e, w_b);
    end
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front(); cmp("mult_busy_a", e, bz_a); cmp("mult_busy_b", e, bz_b);
    end
  end

  task automatic chk_cleared(input string nm);
    chk({nm, "_e_a"}, e_a, 16'h0);  chk({nm, "_e_b"}, e_b, 16'h0);
    chk({nm, "_m_a"}, m_a, 16'h0);  chk({nm, "_m_b"}, m_b, 16'h0);
    chk({nm, "_w_a"}, w_a, 16'h0);  chk({nm, "_w_b"}, w_b, 16'h0);
    chk({nm, "_busy_a"}, bz_a, 16'h0); chk({nm, "_busy_b"}, bz_b, 16'h0);
  endtask

  initial begin
    logic st;
    int   n, idx;
    logic [5:0] ro, rf;

    reset = 1'b0; op = LW; Funct = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset_hold");
    reset = 1'b1;

    drive(LW, 6'd0, 1'b0, 1'b0, st);
    drive(BNE, 6'd0, 1'b0, 1'b0, st);
    drive(BNE, 6'd0, 1'b1, 1'b0, st);
    drive(BEQ, 6'd0, 1'b1, 1'b0, st);
    drive(BEQ, 6'd0, 1'b0, 1'b0, st);
    drive(ORI, 6'd0, 1'b0, 1'b0, st);
    drive(ADDI, 6'd0, 1'b1, 1'b0, st);
    drive(ANDI, 6'd0, 1'b0, 1'b0, st);
    drive(SW, 6'd0, 1'b0, 1'b1, st);
    drive(SW, 6'd0, 1'b0, 1'b0, st);
    drive(JOP, 6'd0, 1'b0, 1'b0, st);
    drive(6'b111111, 6'd0, 1'b0, 1'b0, st);
    drive(RT, 6'b100000, 1'b0, 1'b0, st);
    drive(RT, 6'b100010, 1'b0, 1'b0, st);
    drive(RT, 6'b100100, 1'b0, 1'b0, st);
    drive(RT, 6'b100101, 1'b0, 1'b0, st);
    drive(RT, 6'b101010, 1'b0, 1'b0, st);
    drive(RT, 6'b111111, 1'b0, 1'b0, st);
    repeat (4) drive(RT, 6'd0, 1'b0, 1'b0, st);

    // Back-to-back multiplies: the second is held in D while stalled.
    drive(RT, MULT, 1'b0, 1'b0, st);
    n  = 0;
    st = 1'b1;
    while (st && n < 20) begin
      drive(RT, MULT, 1'b0, 1'b0, st);
      n++;
    end
    repeat (6) drive(RT, 6'd0, 1'b0, 1'b0, st);

    // Asynchronous reset with the tracker at cnt=2.
    drive(RT, MULT, 1'b0, 1'b0, st);
    drive(RT, 6'd0, 1'b0, 1'b0, st);
    drive(RT, 6'd0, 1'b0, 1'b0, st);
    @(posedge clk);
    #1;
    op = RT; Funct = 6'd0; FlushE = 1'b0;
    chk("busy_before_reset", bz_a, 16'h1);
    reset = 1'b0;
    #1;
    chk_cleared("reset_mid_mult");
    qd.delete(); qe.delete(); qm.delete(); qw1.delete(); qw3.delete(); qb.delete();
    last_e = -1000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(RT, MULT, 1'b0, 1'b0, st);
    repeat (8) drive(RT, 6'd0, 1'b0, 1'b0, st);

    ro = RT; rf = 6'd0; st = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!st) begin
        idx = $urandom_range(0, 17);
        rf  = 6'($urandom_range(0, 63));
        case (idx)
          0: ro = LW;   1: ro = SW;   2: ro = BEQ;  3: ro = BNE;
          4: ro = ADDI; 5: ro = ANDI; 6: ro = ORI;  7: ro = JOP;
          8: ro = 6'($urandom_range(0, 63));
          9:  begin ro = RT; rf = 6'b100000; end
          10: begin ro = RT; rf = 6'b100010; end
          11: begin ro = RT; rf = 6'b100100; end
          12: begin ro = RT; rf = 6'b100101; end
          13: begin ro = RT; rf = 6'b101010; end
          default: begin ro = RT; rf = MULT; end
        endcase
      end
      drive(ro, rf, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), st);
    end

    @(posedge clk);
    #1;
    op = RT; Funct = 6'd0; FlushE = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_drained", 16'(qd.size() + qe.size() + qm.size() + qw1.size()
                                  + qw3.size() + qb.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
